// File: rtl/ifm_pkg.sv
// ifm_pkg: shared definitions for the IFM tile feeder.
//   state_e     - feeder FSM states
//   RD_LATENCY  - cycles from an SRAM read strobe to the matching set_ifm
package ifm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/ifm_addr_gen.sv
// ifm_addr_gen: raster-order address generator for one IFM tile.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture base_i / w_i / h_i and restart at pixel (0,0)
//   base_i       : address of pixel (0,0)
//   w_i, h_i     : tile columns / rows
//   adv_i        : current pixel read issued, step to the next one
//   addr_o       : address of the current pixel (wraps mod 2^ADDR_WIDTH)
//   last_o       : current pixel is (h-1, w-1)
module ifm_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [DIM_WIDTH-1:0]  w_i,
  input  logic [DIM_WIDTH-1:0]  h_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
  logic                  col_end;

  assign col_end = (col_q == w_q - ONE);

  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    w_d    = w_q;
    h_d    = h_q;
    if (load_i) begin
      addr_d = base_i;
      col_d  = '0;
      row_d  = '0;
      w_d    = w_i;
      h_d    = h_i;
    end else if (adv_i) begin
      // Row-major tile in contiguous SRAM: a plain +1 covers row changes too.
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      w_q    <= '0;
      h_q    <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
      w_q    <= w_d;
      h_q    <= h_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = col_end && (row_q == h_q - ONE);

endmodule

// File: rtl/ifm_feeder.sv
// ifm_feeder: streams one IFM tile from SRAM into the IFM buffer registers.
//   clk, rst                : clock, asynchronous active-high reset
//   start                   : tile request, accepted only in IDLE
//   base_addr, tile_w/tile_h: tile geometry, captured on accepted start
//   stall                   : holds off issuing new reads
//   mem_rd_en, mem_addr     : SRAM read strobe / address
//   mem_rd_data             : SRAM data, valid one cycle after mem_rd_en
//   set_ifm, ifm_data       : buffer load strobe / pixel (data holds otherwise)
//   ifm_last                : with set_ifm on the final pixel of the tile
//   busy, done              : busy outside IDLE; one-cycle completion pulse
module ifm_feeder
  import ifm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_WIDTH-1:0]  tile_w,
  input  logic [DIM_WIDTH-1:0]  tile_h,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  set_ifm,
  output logic [DATA_WIDTH-1:0] ifm_data,
  output logic                  ifm_last,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic                  zero_tile, load, rd_en, last_px;
  // Bit k marks a read issued k+1 cycles ago; the MSB is the set_ifm stage.
  logic [RD_LATENCY-1:0] vld_q, vld_d, lst_q, lst_d;
  logic [DATA_WIDTH-1:0] ifm_data_q, ifm_data_d;
  logic                  done_q, done_d;

  assign zero_tile = (tile_w == '0) || (tile_h == '0);
  assign load      = (state_q == S_IDLE) && start && !zero_tile;
  assign rd_en     = (state_q == S_RUN) && !stall;

  ifm_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (load),
    .base_i (base_addr),
    .w_i    (tile_w),
    .h_i    (tile_h),
    .adv_i  (rd_en),
    .addr_o (mem_addr),
    .last_o (last_px)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = zero_tile ? S_FINISH : S_RUN;
      S_RUN:    if (rd_en && last_px) state_d = S_DRAIN;
      // Leave once the final read sits in the data-capture stage: FINISH then
      // coincides with its set_ifm and the registered done follows it.
      S_DRAIN:  if (lst_q[RD_LATENCY-2]) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d      = {vld_q[RD_LATENCY-2:0], rd_en};
    lst_d      = {lst_q[RD_LATENCY-2:0], rd_en && last_px};
    // SRAM data is valid one cycle after the strobe; register it as it lands.
    ifm_data_d = vld_q[RD_LATENCY-2] ? mem_rd_data : ifm_data_q;
    done_d     = (state_q == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vld_q      <= '0;
      lst_q      <= '0;
      ifm_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
      ifm_data_q <= ifm_data_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd_en = rd_en;
  assign set_ifm   = vld_q[RD_LATENCY-1];
  assign ifm_last  = lst_q[RD_LATENCY-1];
  assign ifm_data  = ifm_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ifm_feeder.sv
// Testbench for ifm_feeder: directed scenarios plus randomized tiles, checked
// cycle by cycle against a pixel-list reference model.
module tb_ifm_feeder;

  localparam int INF = 32'h3fffffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  tile_w = '0;
  logic [7:0]  tile_h = '0;
  logic        stall = 1'b0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        set_ifm;
  logic [7:0]  ifm_data;
  logic        ifm_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ifm_feeder #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .DIM_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .tile_w      (tile_w),
    .tile_h      (tile_h),
    .stall       (stall),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .set_ifm     (set_ifm),
    .ifm_data    (ifm_data),
    .ifm_last    (ifm_last),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [7:0] pix(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // SRAM model: one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pix(mem_addr);

  // Reference model: a tile is a list of pixels; each issued read becomes an
  // expected output two cycles later; done follows the final output by one.
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  int          start_cyc = INF;
  int          done_cyc = -1;
  int          rem = 0;
  int          idx = 0;
  int          total = 0;
  logic [15:0] base_m = '0;
  logic [7:0]  last_dat = '0;
  int          q_cyc[$];
  logic [7:0]  q_dat[$];
  bit          q_lst[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic set_tile(input logic [15:0] b, input logic [7:0] w, input logic [7:0] h);
    base_addr = b;
    tile_w    = w;
    tile_h    = h;
  endtask

  task automatic cyc(input bit st, input bit sl);
    bit          exp_rd;
    bit          exp_set;
    logic [15:0] ea;
    start = st;
    stall = sl;
    #1;
    exp_rd = (rem > 0) && (n > start_cyc) && !sl;
    ea     = base_m + 16'(idx);
    chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
    if (exp_rd) chk("addr", 32'(mem_addr), 32'(ea));
    exp_set = (q_cyc.size() > 0) && (q_cyc[0] == n);
    chk("set_ifm", 32'(set_ifm), 32'(exp_set));
    if (exp_set) begin
      last_dat = q_dat[0];
      chk("ifm_last", 32'(ifm_last), 32'(q_lst[0]));
      void'(q_cyc.pop_front());
      void'(q_dat.pop_front());
      void'(q_lst.pop_front());
    end else begin
      chk("ifm_last_idle", 32'(ifm_last), 32'(0));
    end
    chk("ifm_data", 32'(ifm_data), 32'(last_dat));
    chk("busy", 32'(busy), 32'((n > start_cyc) && (n < done_cyc)));
    chk("done", 32'(done), 32'(n == done_cyc));
    if (exp_rd) begin
      q_cyc.push_back(n + 2);
      q_dat.push_back(pix(ea));
      q_lst.push_back(idx == total - 1);
      if (idx == total - 1) done_cyc = n + 3;
      idx++;
      rem--;
    end
    if (st && n >= done_cyc) begin
      start_cyc = n;
      base_m    = base_addr;
      total     = int'(tile_w) * int'(tile_h);
      idx       = 0;
      rem       = total;
      done_cyc  = (total == 0) ? n + 2 : INF;
    end
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    #1;
    chk("rst_rd_en", 32'(mem_rd_en), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_set_ifm", 32'(set_ifm), 32'(0));
    chk("rst_ifm_data", 32'(ifm_data), 32'(0));
    chk("rst_ifm_last", 32'(ifm_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_cyc.delete();
    q_dat.delete();
    q_lst.delete();
    rem       = 0;
    idx       = 0;
    start_cyc = INF;
    done_cyc  = -1;
    last_dat  = '0;
    n++;
  endtask

  // Run through the done cycle of the current tile, bounded.
  task automatic run_idle(input int maxc, input bit rnd_stall);
    int k = 0;
    while (n <= done_cyc && k < maxc) begin
      cyc(1'b0, rnd_stall && ($urandom_range(0, 2) == 0));
      k++;
    end
    chk("timeout", 32'(k < maxc), 32'(1));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // 3x2 tile, no stall
    set_tile(16'h0100, 8'd3, 8'd2);
    cyc(1'b1, 1'b0);
    run_idle(50, 1'b0);
    cyc(1'b0, 1'b0);

    // same tile, stall for 3 cycles after the second read
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1);
    run_idle(50, 1'b0);

    // zero-width tile
    set_tile(16'h1234, 8'd0, 8'd5);
    cyc(1'b1, 1'b0);
    run_idle(10, 1'b0);

    // reset after the third read of a 4x4 tile, then a clean fetch
    set_tile(16'h2000, 8'd4, 8'd4);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    do_reset();
    repeat (5) cyc(1'b0, 1'b0);
    set_tile(16'h3000, 8'd4, 8'd4);
    cyc(1'b1, 1'b0);
    run_idle(60, 1'b0);

    // start held high across a 2x2 tile; new geometry only used once idle
    set_tile(16'h0400, 8'd2, 8'd2);
    cyc(1'b1, 1'b0);
    set_tile(16'h0500, 8'd1, 8'd3);
    for (int k = 0; k < 40 && n <= done_cyc; k++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    run_idle(40, 1'b0);

    // address wrap
    set_tile(16'hFFFE, 8'd4, 8'd1);
    cyc(1'b1, 1'b0);
    run_idle(20, 1'b0);

    // randomized tiles with random stall, stray starts and occasional reset
    for (int t = 0; t < 30; t++) begin
      set_tile(($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                           : 16'($urandom),
               8'($urandom_range(0, 5)), 8'($urandom_range(0, 4)));
      cyc(1'b1, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 6)) cyc(1'b0, 1'b0);
        do_reset();
      end else begin
        for (int k = 0; k < 200 && n <= done_cyc; k++) begin
          set_tile(16'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 4)));
          cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        run_idle(200, 1'b1);
      end
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifm_feeder.md
IFM_FEEDER -- requirements
Module: ifm_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning IFM pixel width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, meaning IFM SRAM word-address width.
REQ-003 The block SHALL have parameter DIM_WIDTH, default 8, meaning tile width/height field width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: tile-fetch request, sampled only in IDLE.
REQ-007 The block SHALL have port base_addr, input, ADDR_WIDTH: first pixel address, captured on accepted start.
REQ-008 The block SHALL have ports tile_w and tile_h, inputs, DIM_WIDTH each: tile columns and rows, captured on accepted start.
REQ-009 The block SHALL have port stall, input, 1 bit: pauses issue of new reads.
REQ-010 The block SHALL have port mem_rd_en, output, 1 bit: SRAM read strobe.
REQ-011 The block SHALL have port mem_addr, output, ADDR_WIDTH: SRAM read address.
REQ-012 The block SHALL have port mem_rd_data, input, DATA_WIDTH: SRAM data, valid the cycle after mem_rd_en.
REQ-013 The block SHALL have ports set_ifm (1 bit) and ifm_data (DATA_WIDTH), outputs: load strobe and pixel to the downstream IFM buffer registers.
REQ-014 The block SHALL have port ifm_last, output, 1 bit: high with set_ifm on the final tile pixel.
REQ-015 The block SHALL have ports busy and done, outputs, 1 bit each: busy high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, FINISH.
REQ-017 IDLE->RUN SHALL occur on start=1 with tile_w!=0 and tile_h!=0; start with either dimension 0 SHALL go IDLE->FINISH, issuing no reads.
REQ-018 In RUN, each cycle with stall=0 SHALL assert mem_rd_en with the current address, advancing raster order (column first, then row), address = base_addr + row*tile_w + col, implemented as a running +1 increment, mod 2^ADDR_WIDTH.
REQ-019 In RUN with stall=1, mem_rd_en SHALL be 0 and address/counters SHALL hold.
REQ-020 RUN->DRAIN SHALL occur in the cycle after the read of pixel (tile_h-1, tile_w-1) is issued.
REQ-021 set_ifm SHALL be registered: high exactly 2 cycles after each mem_rd_en, with ifm_data equal to mem_rd_data sampled 1 cycle after that mem_rd_en.
REQ-022 stall SHALL NOT suppress reads already in flight; their set_ifm pulses SHALL still occur.
REQ-023 ifm_data SHALL hold its last value when set_ifm=0.
REQ-024 DRAIN->FINISH SHALL occur once no read is in flight and the last set_ifm has been output; FINISH SHALL assert done for one cycle, then return to IDLE.
REQ-025 start asserted outside IDLE SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-026 Pixel count SHALL be tile_w*tile_h, exactly one set_ifm per pixel, max (2^DIM_WIDTH-1)^2.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and all outputs (mem_rd_en, mem_addr, set_ifm, ifm_data, ifm_last, busy, done) and counters to 0.
REQ-028 rst mid-tile SHALL abort; in-flight reads SHALL produce no set_ifm after rst, and no done SHALL be produced.

Structure
REQ-029 FSM state encodings and the read-to-output latency constant (2) SHALL live in a shared package, ifm_pkg.
REQ-030 The block SHALL be flat except one natural sub-module, ifm_addr_gen (row/col counters, address increment, last-pixel flag).

Verification
REQ-031 base_addr=0x0100, tile_w=3, tile_h=2, stall=0 -> mem_addr 0x0100..0x0105 on consecutive cycles, six set_ifm, ifm_last on the sixth, done the cycle after the sixth.
REQ-032 Same tile with stall=1 for 3 cycles after the second read -> no mem_rd_en for 3 cycles, second pixel's set_ifm still occurs, all six pixels in order, done once.
REQ-033 start with tile_w=0, tile_h=5 -> no mem_rd_en, no set_ifm, done pulses 2 cycles after start.
REQ-034 rst pulsed after the third read of a 4x4 tile -> outputs 0 at once, no further set_ifm or done; new start fetches correctly.
REQ-035 start held high throughout a 2x2 tile -> start during RUN/DRAIN/FINISH ignored; second tile begins only after return to IDLE.
REQ-036 base_addr=0xFFFE, tile 4x1 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
